// File: rtl/note_pkg.sv
// Shared types and constants for the note tone generator: note codes, pitch
// frequencies, the half-period helper and the player state encoding.
package note_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        A1   = 4'd1,
        A2   = 4'd2,
        B1   = 4'd3,
        C1   = 4'd4,
        D1   = 4'd5,
        E2   = 4'd6,
        G1   = 4'd7,
        G2   = 4'd8,
        F1   = 4'd9,
        F2H  = 4'd10
    } note_e;

    localparam int unsigned F_A1  = 220;
    localparam int unsigned F_A2  = 440;
    localparam int unsigned F_B1  = 247;
    localparam int unsigned F_C1  = 262;
    localparam int unsigned F_D1  = 294;
    localparam int unsigned F_E2  = 330;
    localparam int unsigned F_G1  = 196;
    localparam int unsigned F_G2  = 392;
    localparam int unsigned F_F1  = 175;
    localparam int unsigned F_F2H = 370;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        PLAY   = 2'd1,
        GAP    = 2'd2
    } state_e;

    // Half-period in clock cycles; 0 marks a silent code.
    function automatic int unsigned half_period(input logic [3:0] code,
                                                input int unsigned clk_freq);
        int unsigned f;
        case (note_e'(code))
            A1:      f = F_A1;
            A2:      f = F_A2;
            B1:      f = F_B1;
            C1:      f = F_C1;
            D1:      f = F_D1;
            E2:      f = F_E2;
            G1:      f = F_G1;
            G2:      f = F_G2;
            F1:      f = F_F1;
            F2H:     f = F_F2H;
            default: f = 0;
        endcase
        if (f == 0) begin
            return 0;
        end
        return clk_freq / (2 * f);
    endfunction

endpackage

// File: rtl/note_period_rom.sv
// Constant code -> half-period table built at elaboration; silent codes read 0.
module note_period_rom
    import note_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic [3:0]       code,
    output logic [CNT_W-1:0] hp_c,
    output logic             is_sound_c
);

    logic [CNT_W-1:0] tab [16];

    for (genvar i = 0; i < 16; i++) begin : g_tab
        localparam int unsigned HP = half_period(4'(i), CLK_FREQ);
        // A sounding code must fit the counter and give a usable half-period.
        if (HP != 0 && (HP < 2 || 64'(HP) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad
            $error("note_period_rom: half-period %0d for code %0d out of range", HP, i);
        end
        assign tab[i] = CNT_W'(HP);
    end

    assign hp_c       = tab[code];
    assign is_sound_c = (tab[code] != '0);

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave buzzer driver: plays the sampled note, switching notes only at
// full-period boundaries with an optional silent articulation gap.
module note_tone_gen
    import note_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned GAP_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] note,
    output logic       buzzer,
    output logic       playing,
    output logic [3:0] cur_note
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned CW    = (CNT_W > GAP_W) ? CNT_W : GAP_W;
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES != 0) ? GAP_CYCLES - 1 : 0);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] hp_c;
    logic [CNT_W-1:0] new_reload_c;
    logic             is_sound_c;

    note_period_rom #(
        .CLK_FREQ (CLK_FREQ),
        .CNT_W    (CNT_W)
    ) u_rom (
        .code       (note),
        .hp_c       (hp_c),
        .is_sound_c (is_sound_c)
    );

    assign new_reload_c = hp_c - CNT_W'(1);

    // Player FSM; enable low overrides every other transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SILENT;
            cnt      <= '0;
            reload   <= '0;
            buzzer   <= 1'b0;
            playing  <= 1'b0;
            cur_note <= 4'd0;
        end else if (!enable) begin
            state    <= SILENT;
            cnt      <= '0;
            buzzer   <= 1'b0;
            playing  <= 1'b0;
            cur_note <= 4'd0;
        end else begin
            case (state)
                SILENT: begin
                    cnt <= '0;
                    if (is_sound_c) begin
                        state    <= PLAY;
                        cur_note <= note;
                        reload   <= new_reload_c;
                        cnt      <= CW'(new_reload_c);
                        buzzer   <= 1'b1;
                        playing  <= 1'b1;
                    end
                end
                PLAY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (buzzer) begin
                        buzzer <= 1'b0;
                        cnt    <= CW'(reload);
                    end else if (note == cur_note) begin
                        buzzer <= 1'b1;
                        cnt    <= CW'(reload);
                    end else if (!is_sound_c) begin
                        state    <= SILENT;
                        playing  <= 1'b0;
                        cur_note <= 4'd0;
                    end else if (GAP_CYCLES != 0) begin
                        state    <= GAP;
                        cnt      <= GAP_LOAD;
                        playing  <= 1'b0;
                        cur_note <= 4'd0;
                    end else begin
                        cur_note <= note;
                        reload   <= new_reload_c;
                        cnt      <= CW'(new_reload_c);
                        buzzer   <= 1'b1;
                    end
                end
                GAP: begin
                    buzzer <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (is_sound_c) begin
                        state    <= PLAY;
                        cur_note <= note;
                        reload   <= new_reload_c;
                        cnt      <= CW'(new_reload_c);
                        buzzer   <= 1'b1;
                        playing  <= 1'b1;
                    end else begin
                        state <= SILENT;
                    end
                end
                default: begin
                    state    <= SILENT;
                    cnt      <= '0;
                    buzzer   <= 1'b0;
                    playing  <= 1'b0;
                    cur_note <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen at CLK_FREQ=8800: one instance with a
// 4-cycle gap, one with the gap disabled, driven by the same stimulus.
module tb_note_tone_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] note = 4'd0;

    logic       buzzer0, playing0;
    logic [3:0] cur_note0;
    logic       buzzer1, playing1;
    logic [3:0] cur_note1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    note_tone_gen #(.CLK_FREQ(8800), .CNT_W(20), .GAP_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .note(note),
        .buzzer(buzzer0), .playing(playing0), .cur_note(cur_note0)
    );

    note_tone_gen #(.CLK_FREQ(8800), .CNT_W(20), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .note(note),
        .buzzer(buzzer1), .playing(playing1), .cur_note(cur_note1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        note   = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (buzzer0 !== 1'b0 || playing0 !== 1'b0 || cur_note0 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: buzzer=%b playing=%b cur_note=%0d, required 0/0/0",
                     buzzer0, playing0, cur_note0);
        end
        rst = 1'b0;
        enable = 1'b0;
        note = 4'd2;
        tick();
        n_cmp++;
        if (buzzer0 !== 1'b0 || playing0 !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_idle: buzzer=%b playing=%b, required 0/0", buzzer0, playing0);
        end
    endtask

    task automatic test_play_a2();
        logic exp_b;
        do_reset();
        enable = 1'b1;
        note   = 4'd2;
        for (int k = 0; k <= 40; k++) begin
            tick();
            exp_b = ((k / 10) % 2 == 0);
            n_cmp++;
            if (buzzer0 !== exp_b || playing0 !== 1'b1 || cur_note0 !== 4'd2) begin
                n_fail++;
                $display("FAIL play_a2 edge %0d: buzzer=%b playing=%b cur_note=%0d, required %b/1/2",
                         k, buzzer0, playing0, cur_note0, exp_b);
            end
        end
    endtask

    task automatic test_gap_change();
        logic       exp_b, exp_p;
        logic [3:0] exp_c;
        do_reset();
        enable = 1'b1;
        note   = 4'd2;
        for (int k = 0; k <= 47; k++) begin
            if (k == 4) note = 4'd8;
            tick();
            exp_b = (k <= 9) ? 1'b1 : (k <= 23) ? 1'b0 : (k <= 34) ? 1'b1 : (k <= 45) ? 1'b0 : 1'b1;
            exp_c = (k <= 19) ? 4'd2 : (k <= 23) ? 4'd0 : 4'd8;
            exp_p = !(k >= 20 && k <= 23);
            n_cmp++;
            if (buzzer0 !== exp_b || playing0 !== exp_p || cur_note0 !== exp_c) begin
                n_fail++;
                $display("FAIL gap_change edge %0d: buzzer=%b playing=%b cur_note=%0d, required %b/%b/%0d",
                         k, buzzer0, playing0, cur_note0, exp_b, exp_p, exp_c);
            end
        end
    endtask

    task automatic test_no_gap_change();
        logic       exp_b;
        logic [3:0] exp_c;
        do_reset();
        enable = 1'b1;
        note   = 4'd2;
        for (int k = 0; k <= 71; k++) begin
            if (k == 4) note = 4'd9;
            tick();
            exp_b = (k <= 9) ? 1'b1 : (k <= 19) ? 1'b0 : (k <= 44) ? 1'b1 : (k <= 69) ? 1'b0 : 1'b1;
            exp_c = (k <= 19) ? 4'd2 : 4'd9;
            n_cmp++;
            if (buzzer1 !== exp_b || playing1 !== 1'b1 || cur_note1 !== exp_c) begin
                n_fail++;
                $display("FAIL no_gap_change edge %0d: buzzer=%b playing=%b cur_note=%0d, required %b/1/%0d",
                         k, buzzer1, playing1, cur_note1, exp_b, exp_c);
            end
        end
    endtask

    task automatic test_silence();
        logic [3:0] codes [2];
        logic       exp_b, exp_p;
        logic [3:0] exp_c;
        codes[0] = 4'd0;
        codes[1] = 4'd12;
        for (int c = 0; c < 2; c++) begin
            do_reset();
            enable = 1'b1;
            note   = 4'd2;
            for (int k = 0; k <= 25; k++) begin
                if (k == 4) note = codes[c];
                tick();
                exp_b = (k <= 9);
                exp_p = (k <= 19);
                exp_c = (k <= 19) ? 4'd2 : 4'd0;
                n_cmp++;
                if (buzzer0 !== exp_b || playing0 !== exp_p || cur_note0 !== exp_c) begin
                    n_fail++;
                    $display("FAIL silence_code%0d edge %0d: buzzer=%b playing=%b cur_note=%0d, required %b/%b/%0d",
                             codes[c], k, buzzer0, playing0, cur_note0, exp_b, exp_p, exp_c);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic       exp_b;
        logic [3:0] exp_c;
        do_reset();
        enable = 1'b1;
        note   = 4'd2;
        for (int k = 0; k <= 6; k++) begin
            if (k == 4) enable = 1'b0;
            tick();
            exp_b = (k <= 3);
            exp_c = (k <= 3) ? 4'd2 : 4'd0;
            n_cmp++;
            if (buzzer0 !== exp_b || playing0 !== exp_b || cur_note0 !== exp_c) begin
                n_fail++;
                $display("FAIL enable_drop edge %0d: buzzer=%b playing=%b cur_note=%0d, required %b/%b/%0d",
                         k, buzzer0, playing0, cur_note0, exp_b, exp_b, exp_c);
            end
        end
        // Drop enable exactly on the edge where the next period would start.
        do_reset();
        enable = 1'b1;
        note   = 4'd2;
        for (int k = 0; k <= 19; k++) tick();
        enable = 1'b0;
        tick();
        n_cmp++;
        if (buzzer0 !== 1'b0 || playing0 !== 1'b0 || cur_note0 !== 4'd0) begin
            n_fail++;
            $display("FAIL enable_drop_boundary: buzzer=%b playing=%b cur_note=%0d, required 0/0/0",
                     buzzer0, playing0, cur_note0);
        end
    endtask

    task automatic test_reset_mid_play();
        logic exp_b;
        do_reset();
        enable = 1'b1;
        note   = 4'd2;
        for (int k = 0; k <= 21; k++) begin
            if (k == 4) note = 4'd8;
            tick();
        end
        n_cmp++;
        if (buzzer0 !== 1'b0 || playing0 !== 1'b0 || cur_note0 !== 4'd0) begin
            n_fail++;
            $display("FAIL in_gap: buzzer=%b playing=%b cur_note=%0d, required 0/0/0",
                     buzzer0, playing0, cur_note0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (buzzer0 !== 1'b0 || playing0 !== 1'b0 || cur_note0 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_gap: buzzer=%b playing=%b cur_note=%0d, required 0/0/0",
                     buzzer0, playing0, cur_note0);
        end
        #1 rst = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            tick();
            exp_b = (k <= 10) || (k >= 22);
            n_cmp++;
            if (buzzer0 !== exp_b || playing0 !== 1'b1 || cur_note0 !== 4'd8) begin
                n_fail++;
                $display("FAIL restart_g2 edge %0d: buzzer=%b playing=%b cur_note=%0d, required %b/1/8",
                         k, buzzer0, playing0, cur_note0, exp_b);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (buzzer0 !== 1'b0 || playing0 !== 1'b0 || cur_note0 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_high: buzzer=%b playing=%b cur_note=%0d, required 0/0/0",
                     buzzer0, playing0, cur_note0);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_b;
        do_reset();
        enable = 1'b1;
        note   = 4'd2;
        for (int k = 0; k <= 45; k++) begin
            if (k == 3)  note = 4'd8;
            if (k == 12) note = 4'd2;
            tick();
            exp_b = ((k / 10) % 2 == 0);
            n_cmp++;
            if (buzzer0 !== exp_b || playing0 !== 1'b1 || cur_note0 !== 4'd2 ||
                buzzer1 !== exp_b || cur_note1 !== 4'd2) begin
                n_fail++;
                $display("FAIL back_to_back edge %0d: buzzer=%b/%b cur_note=%0d/%0d playing=%b, required %b/%b 2/2 1",
                         k, buzzer0, buzzer1, cur_note0, cur_note1, playing0, exp_b, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_play_a2();
        test_gap_change();
        test_no_gap_change();
        test_silence();
        test_enable_drop();
        test_reset_mid_play();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
